// File: rtl/audio_i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx_if
// Purpose  : Valid/ready sample stream feeding the I2S transmitter.
// Revision : 1.0
// ============================================================================
interface audio_i2s_tx_if #(
    parameter int SAMPLE_SIZE = 16
) ();
    logic                   tvalid;
    logic [SAMPLE_SIZE-1:0] tdata;
    logic                   tready;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Purpose  : Serialises mono samples as I2S frames (same sample on L and R).
// Revision : 1.0
// ============================================================================
module audio_i2s_tx #(
    parameter int SAMPLE_SIZE = 16,
    parameter int BCLK_DIV    = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    audio_i2s_tx_if.slave   s_stream,
    output logic            bclk,
    output logic            lrclk,
    output logic            sdata,
    output logic            underrun
);
    localparam int c_DIV_W = $clog2(BCLK_DIV) + 1;
    localparam int c_BIT_W = $clog2(2 * SAMPLE_SIZE);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2 * SAMPLE_SIZE - 1);
    localparam logic [c_BIT_W-1:0] c_LR_FIRST = c_BIT_W'(SAMPLE_SIZE - 1);
    localparam logic [c_BIT_W-1:0] c_LR_LAST  = c_BIT_W'(2 * SAMPLE_SIZE - 2);

    logic [c_DIV_W-1:0]     div_cnt_q,   div_cnt_d;
    logic                   bclk_q,      bclk_d;
    logic [c_BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [SAMPLE_SIZE-1:0] hold_q,      hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [SAMPLE_SIZE-1:0] shift_q,     shift_d;
    logic                   sdata_q,     sdata_d;
    logic                   lrclk_q,     lrclk_d;
    logic                   underrun_q,  underrun_d;

    logic                     w_div_wrap;
    logic                     w_strobe;
    logic                     w_load;
    logic                     w_txn;
    logic [2*SAMPLE_SIZE-1:0] w_frame;

    assign w_div_wrap      = (div_cnt_q == c_DIV_LAST);
    assign w_strobe        = w_div_wrap && bclk_q;
    assign w_load          = w_strobe && (bit_cnt_q == c_BIT_LAST);
    assign w_txn           = s_stream.tvalid && !hold_full_q;
    assign s_stream.tready = !hold_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= c_BIT_LAST;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            sdata_q     <= 1'b0;
            lrclk_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            sdata_q     <= sdata_d;
            lrclk_q     <= lrclk_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        div_cnt_d   = w_div_wrap ? '0 : div_cnt_q + c_DIV_W'(1);
        bclk_d      = w_div_wrap ? !bclk_q : bclk_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        sdata_d     = sdata_q;
        lrclk_d     = lrclk_q;
        underrun_d  = 1'b0;
        w_frame     = '0;

        if (w_strobe) begin
            bit_cnt_d = w_load ? '0 : bit_cnt_q + c_BIT_W'(1);
            if (w_load) begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    shift_d    = '0;
                    underrun_d = 1'b1;
                end
            end
            // Two copies back to back: one reversed index covers both slots MSB first.
            w_frame = {shift_d, shift_d};
            sdata_d = w_frame[c_BIT_LAST - bit_cnt_d];
            lrclk_d = (bit_cnt_d >= c_LR_FIRST) && (bit_cnt_d <= c_LR_LAST);
        end

        // Accepting only when empty means a sample never reaches the shifter in its arrival cycle.
        if (w_txn) begin
            hold_d      = s_stream.tdata;
            hold_full_d = 1'b1;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_tx
// Purpose  : Directed bench for audio_i2s_tx (16/4 and 8/1 instances) with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_audio_i2s_tx;
    int c_ss [2] = '{16, 8};
    int c_b  [2] = '{4, 1};

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_i2s_tx_if #(.SAMPLE_SIZE(16)) if0 ();
    audio_i2s_tx_if #(.SAMPLE_SIZE(8))  if1 ();

    logic bclk0, lr0, sd0, un0;
    logic bclk1, lr1, sd1, un1;

    audio_i2s_tx #(.SAMPLE_SIZE(16), .BCLK_DIV(4)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_stream(if0),
        .bclk(bclk0), .lrclk(lr0), .sdata(sd0), .underrun(un0)
    );
    audio_i2s_tx #(.SAMPLE_SIZE(8), .BCLK_DIV(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s_stream(if1),
        .bclk(bclk1), .lrclk(lr1), .sdata(sd1), .underrun(un1)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: clk edges since reset release, the sample being sent this frame, and the holding slot.
    int          m_n     [2] = '{0, 0};
    logic        m_full  [2] = '{1'b0, 1'b0};
    logic [15:0] m_hold  [2] = '{16'h0, 16'h0};
    logic [15:0] m_frame [2] = '{16'h0, 16'h0};
    logic        m_under [2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_n[i] = 0; m_full[i] = 1'b0; m_hold[i] = '0; m_frame[i] = '0; m_under[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input logic tv, input logic [15:0] td);
        int  ss = c_ss[i];
        int  b  = c_b[i];
        int  n;
        logic txn;
        txn = tv && !m_full[i];
        m_n[i]++;
        n = m_n[i];
        m_under[i] = 1'b0;
        if ((n % (2*b)) == 0 && (((n / (2*b)) - 1) % (2*ss)) == 0) begin
            if (m_full[i]) begin
                m_frame[i] = m_hold[i];
                m_full[i]  = 1'b0;
            end else begin
                m_frame[i] = '0;
                m_under[i] = 1'b1;
            end
        end
        if (txn) begin
            m_hold[i] = td;
            m_full[i] = 1'b1;
        end
    endtask

    // {bclk, lrclk, sdata, underrun} after m_n edges
    function automatic logic [3:0] exp_outs(input int i);
        int ss = c_ss[i];
        int b  = c_b[i];
        int n  = m_n[i];
        int s  = n / (2*b);
        int k;
        logic bc, lr, sd;
        bc = ((n / b) % 2) == 1;
        if (s == 0) begin
            lr = 1'b0;
            sd = 1'b0;
        end else begin
            k  = (s - 1) % (2*ss);
            lr = (k >= ss - 1) && (k <= 2*ss - 2);
            sd = m_frame[i][(k < ss) ? (ss - 1 - k) : (2*ss - 1 - k)];
        end
        return {bc, lr, sd, m_under[i]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, if0.tvalid, if0.tdata);
            model_step(1, if1.tvalid, {8'h00, if1.tdata});
        end
    end

    logic [4:0] cmp_e0, cmp_g0, cmp_e1, cmp_g1;
    always @(negedge clk) begin
        cmp_e0 = {exp_outs(0), !m_full[0]};
        cmp_g0 = {bclk0, lr0, sd0, un0, if0.tready};
        check($sformatf("model0 n=%0d {bclk,lr,sd,un,rdy}", m_n[0]), {27'd0, cmp_g0}, {27'd0, cmp_e0});
        cmp_e1 = {exp_outs(1), !m_full[1]};
        cmp_g1 = {bclk1, lr1, sd1, un1, if1.tready};
        check($sformatf("model1 n=%0d {bclk,lr,sd,un,rdy}", m_n[1]), {27'd0, cmp_g1}, {27'd0, cmp_e1});
    end

    task automatic wait_to(input int n);
        int guard = 0;
        while (m_n[0] < n && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check($sformatf("reach edge %0d", n), m_n[0], n);
    endtask

    task automatic send0(input logic [15:0] v);
        int   g = 0;
        logic acc;
        if0.tvalid = 1'b1;
        if0.tdata  = v;
        do begin
            acc = if0.tready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 600);
        if0.tvalid = 1'b0;
        check($sformatf("accept0 %h", v), acc, 1);
    endtask

    task automatic send1(input logic [7:0] v);
        int   g = 0;
        logic acc;
        if1.tvalid = 1'b1;
        if1.tdata  = v;
        do begin
            acc = if1.tready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if1.tvalid = 1'b0;
        check($sformatf("accept1 %h", v), acc, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        if0.tvalid = 1'b0; if0.tdata = '0;
        if1.tvalid = 1'b0; if1.tdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle first frame: underrun on the first bclk fall
        wait_to(2);  check("t6 first load underrun", un1, 1);
        wait_to(3);  check("t1 bclk low", bclk0, 0);
        wait_to(4);  check("t1 bclk rise", bclk0, 1);
        wait_to(8);  check("t1 underrun", un0, 1); check("t1 bclk fall", bclk0, 0);
        wait_to(9);  check("t1 underrun one cycle", un0, 0);

        // Single sample accepted during frame 0, sent in frame 1
        wait_to(100);
        send0(16'hA5C3);
        check("t2 tready low", if0.tready, 0);
        wait_to(128); check("t1 lrclk lead", lr0, 1); check("t1 zero data", sd0, 0);
        wait_to(264); check("t2 L msb", sd0, 1); check("t2 no underrun", un0, 0);
                      check("t2 tready back", if0.tready, 1);
        wait_to(272); check("t2 L bit14", sd0, 0);
        wait_to(392); check("t2 R msb", sd0, 1); check("t2 R lrclk", lr0, 1);
        wait_to(512); check("t2 R lsb", sd0, 1); check("t2 lrclk lead L", lr0, 0);

        // Continuous stream
        send0(16'h0001);
        send0(16'h8000);
        send0(16'h7FFF);
        wait_to(1032); check("t3 7FFF msb", sd0, 0); check("t3 no underrun", un0, 0);
        wait_to(1040); check("t3 7FFF bit14", sd0, 1);

        // tvalid exactly in the load cycle with hold empty
        wait_to(1287);
        if0.tvalid = 1'b1;
        if0.tdata  = 16'h5A5A;
        wait_to(1288);
        if0.tvalid = 1'b0;
        check("t4 underrun", un0, 1); check("t4 zero msb", sd0, 0); check("t4 stored", if0.tready, 0);
        wait_to(1544); check("t4 5A5A msb", sd0, 0); check("t4 no underrun", un0, 0);
        wait_to(1552); check("t4 5A5A bit14", sd0, 1);

        // Reset mid-frame with a held sample
        wait_to(1600);
        send0(16'hFFFF);
        wait_to(1709);
        check("t5 pre bclk", bclk0, 1); check("t5 pre lrclk", lr0, 1);
        check("t5 pre sdata", sd0, 1);  check("t5 pre held", if0.tready, 0);
        reset_n = 1'b0;
        #1;
        check("t5 async bclk", bclk0, 0); check("t5 async lrclk", lr0, 0);
        check("t5 async sdata", sd0, 0);  check("t5 tready in reset", if0.tready, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_to(8); check("t5 held discarded", un0, 1); check("t5 zero data", sd0, 0);

        // BCLK_DIV=1, SAMPLE_SIZE=8 instance
        wait_to(10);
        send1(8'h96);
        send1(8'h3C);
        send1(8'hC1);
        wait_to(98);  check("t6 C1 msb", sd1, 1); check("t6 no underrun", un1, 0);
        wait_to(99);  check("t6 bclk high", bclk1, 1);
        wait_to(100); check("t6 bclk low", bclk1, 0); check("t6 C1 bit6", sd1, 1);
        wait_to(110); check("t6 lrclk k6", lr1, 0); check("t6 C1 bit1", sd1, 0);
        wait_to(112); check("t6 lrclk lead", lr1, 1); check("t6 C1 lsb", sd1, 1);
        wait_to(114); check("t6 R msb", sd1, 1); check("t6 R lrclk", lr1, 1);
        wait_to(128); check("t6 lrclk k15", lr1, 0); check("t6 R lsb", sd1, 1);
        wait_to(130); check("t6 frame 32 underrun", un1, 1); check("t6 zero msb", sd1, 0);

        wait_to(200);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Consumer end of the oscillator's sample stream.
- Accepts SAMPLE_SIZE-bit signed samples over a valid/ready stream handshake and serialises each one as a standard I2S frame to an external DAC.
- Each mono sample is sent on both the left and right channels.
- The I2S frame timing sets the backpressure, so the upstream source advances exactly once per output frame.
- Sample rate fs = clk / (4 * BCLK_DIV * SAMPLE_SIZE). Example: 12.288 MHz clk, BCLK_DIV=4, SAMPLE_SIZE=16 gives 48 kHz.

Parameters:
- SAMPLE_SIZE, 16, bits per sample and bits per I2S channel slot.
- BCLK_DIV, 4, clk cycles per bclk half-period; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- tvalid  input  1  upstream sample valid.
- tdata  input  SAMPLE_SIZE  upstream sample, two's complement.
- tready  output  1  block can accept a sample.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- underrun  output  1  one-cycle pulse when a frame starts with no sample held.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Registers take these values immediately on reset_n low: bclk=0, lrclk=0, sdata=0, underrun=0, hold_full=0, div_cnt=0, bit_cnt=2*SAMPLE_SIZE-1, shift=0.
- Handshake:
  - tready = !hold_full, combinational from the register. It reads 1 during reset; that is harmless because the source holds tvalid=0 in reset.
  - Transaction = tvalid & tready. On a transaction, hold <= tdata and hold_full <= 1.
  - tdata is ignored when there is no transaction.
- Bit clock:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - At div_cnt==BCLK_DIV-1, bclk toggles.
  - Bit strobe = cycle where div_cnt==BCLK_DIV-1 and bclk==1, i.e. the bclk falling edge.
  - All serial outputs change only on bit strobes. The DAC samples on the rising edge.
- Bit counter:
  - bit_cnt counts 0..2*SAMPLE_SIZE-1.
  - On each bit strobe it increments and wraps to 0 after 2*SAMPLE_SIZE-1.
- Frame load, on the bit strobe where bit_cnt wraps to 0:
  - If hold_full: shift <= hold, hold_full <= 0.
  - Else: shift <= 0 and underrun pulses high for that single clk cycle.
- Serial data:
  - sdata is registered.
  - On a strobe with new bit_cnt k < SAMPLE_SIZE: sdata = shift[SAMPLE_SIZE-1-k] (left slot).
  - For k >= SAMPLE_SIZE: sdata = shift[2*SAMPLE_SIZE-1-k] (right slot, same sample).
  - sdata therefore becomes the loaded MSB in the same strobe that loads the frame.
- Word select:
  - lrclk is registered and updated on strobes.
  - lrclk = 1 when new bit_cnt is in [SAMPLE_SIZE-1, 2*SAMPLE_SIZE-2], else 0.
  - This gives the I2S one-bit lead: lrclk changes one bclk before each slot's MSB.
- First frame after reset:
  - bclk first rises after BCLK_DIV cycles and first falls after 2*BCLK_DIV cycles.
  - That first strobe wraps bit_cnt to 0 and performs a frame load.
- Simultaneous transaction and frame load in the same cycle:
  - Only possible when hold is empty, so the load sees empty: underrun pulses and zeros are sent.
  - The arriving sample is stored in hold and waits for the next frame.
  - A sample is never forwarded in the same cycle it is accepted.
- Steady state: hold refills within one frame, so tready is high for at most one frame per sample.
- Reset mid-frame: outputs return to their reset values at once. The partial frame is abandoned and the held sample is discarded.
- Widths:
  - div_cnt is $clog2(BCLK_DIV)+1 bits; with BCLK_DIV=1, div_cnt stays 0 and bclk toggles every cycle.
  - bit_cnt is $clog2(2*SAMPLE_SIZE) bits.

Test Plan:
1. Reset release, SAMPLE_SIZE=16, BCLK_DIV=4, tvalid=0 -> bclk period 8 clk; first bclk fall at cycle 8 with underrun pulse; sdata stays 0; lrclk high during bit_cnt 15..30; frame length 256 clk.
2. Single sample 16'hA5C3 presented before the first frame -> accepted immediately (tready 1->0); left slot and right slot each carry A5C3 MSB first; tready returns to 1 right after the load strobe; no underrun.
3. Continuous source streaming 0x0001, 0x8000, 0x7FFF -> one handshake per 256-clk frame; frames carry those values in order on both channels; underrun never asserts after the first frame.
4. Source asserts tvalid in exactly the frame-load cycle with hold empty -> underrun pulses one cycle; that frame is all zeros; the sample appears in the following frame.
5. reset_n pulled low at bit_cnt=20 with hold_full=1 -> bclk, lrclk and sdata go 0 asynchronously; after release the first frame underruns (held sample discarded).
6. BCLK_DIV=1, SAMPLE_SIZE=8 -> bclk toggles every clk; frame is 32 clk; lrclk leads each slot MSB by one bclk; data bits are correct.
